// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding and mode constants for the pulse-train generator
package pulse_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;
endpackage

// File: rtl/pulse_channel.sv
// pulse_channel: one independent pulse-train FSM with shadowed settings and registered outputs
module pulse_channel
    import pulse_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] count,
    output logic             signal,
    output logic             busy,
    output logic             done
);
    state_t           st;
    logic [CNT_W-1:0] ph, pc, hl, ll;
    logic             md;

    // A programmed width of 0 still yields one cycle in that phase
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st     <= IDLE;
            ph     <= '0;
            pc     <= '0;
            hl     <= '0;
            ll     <= '0;
            md     <= MODE_ONESHOT;
            signal <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                st     <= IDLE;
                signal <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (st)
                    IDLE: if (start) begin
                        hl <= high_len;
                        ll <= low_len;
                        md <= mode;
                        pc <= count;
                        if (mode == MODE_ONESHOT && count == '0) begin
                            done <= 1'b1;
                        end else begin
                            st     <= HIGH;
                            signal <= 1'b1;
                            busy   <= 1'b1;
                            ph     <= at_least_one(high_len);
                        end
                    end
                    HIGH: if (ph == CNT_W'(1)) begin
                        signal <= 1'b0;
                        if (md == MODE_ONESHOT && pc == CNT_W'(1)) begin
                            st   <= IDLE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            st <= LOW;
                            ph <= at_least_one(ll);
                            pc <= (md == MODE_ONESHOT) ? pc - 1'b1 : pc;
                        end
                    end else begin
                        ph <= ph - 1'b1;
                    end
                    LOW: if (ph == CNT_W'(1)) begin
                        st     <= HIGH;
                        signal <= 1'b1;
                        ph     <= at_least_one(hl);
                    end else begin
                        ph <= ph - 1'b1;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: multi-channel programmable pulse-train generator
module pulse_train_gen #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*CNT_W-1:0] high_len,
    input  logic [CHANNELS*CNT_W-1:0] low_len,
    input  logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       signal,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
);
    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_channel #(.CNT_W(CNT_W)) u_ch (
            .clock    (clock),
            .reset    (reset),
            .start    (start[i]),
            .stop     (stop[i]),
            .mode     (mode[i]),
            .high_len (high_len[i*CNT_W +: CNT_W]),
            .low_len  (low_len[i*CNT_W +: CNT_W]),
            .count    (count[i*CNT_W +: CNT_W]),
            .signal   (signal[i]),
            .busy     (busy[i]),
            .done     (done[i])
        );
    end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Parametrised multi-channel pulse-train generator, the synthesisable successor to the fixed-pattern pulse stimulus blocks in the timing exercises. Each channel independently emits a programmable number of pulses with programmable high and low widths (in clock cycles), in one-shot or continuous mode. It sits beside the free-running clock source and drives test waveforms and strobes into downstream sequential blocks.

## Interface
- `CHANNELS`, 2, number of independent channels (1..8)
- `CNT_W`, 8, width of the length and count fields
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  CHANNELS  per-channel start request, sampled on rising edge
- `stop`  in  CHANNELS  per-channel synchronous abort
- `mode`  in  CHANNELS  per-channel mode: 0 = one-shot, 1 = continuous
- `high_len`  in  CHANNELS*CNT_W  high width in cycles; channel i uses bits [i*CNT_W +: CNT_W]
- `low_len`  in  CHANNELS*CNT_W  low width in cycles, same packing
- `count`  in  CHANNELS*CNT_W  pulses per burst in one-shot mode, same packing
- `signal`  out  CHANNELS  pulse outputs
- `busy`  out  CHANNELS  high while the channel is not IDLE
- `done`  out  CHANNELS  one-cycle strobe when a one-shot burst completes

## Operation
- Per-channel FSM with states IDLE, HIGH and LOW. Channels share no state.
- IDLE, `start[i]=1`, `stop[i]=0`: the channel latches `high_len`, `low_len`, `count` and `mode` into shadow registers and enters HIGH. Input changes after this have no effect until the next start.
- HIGH: `signal=1` for exactly H cycles, where H = max(high_len, 1). The channel then enters LOW. Exception: in one-shot mode, if this was the last pulse, the channel returns to IDLE instead.
- LOW: `signal=0` for exactly L cycles, where L = max(low_len, 1). The channel then returns to HIGH.
- One-shot: a pulse counter is loaded with `count` and decremented at the end of each HIGH phase. The channel emits exactly `count` pulses and then goes to IDLE. `done` is asserted for 1 cycle on the cycle `signal` first reads 0 after the last pulse. No trailing LOW phase.
- `count=0` in one-shot: no pulse is emitted. The channel stays IDLE, and `done` is asserted for 1 cycle, one cycle after the start.
- Continuous: the channel alternates HIGH and LOW indefinitely. `count` is ignored and `done` is never asserted.
- `stop[i]=1` in any state: next cycle the channel is IDLE with `signal=0` and `busy=0`, and no `done` is asserted.
- `start` and `stop` on the same cycle: `stop` wins.
- `start` while busy: ignored, no restart.
- Phase counters are CNT_W bits wide and count down to 1. No wrap-around is possible; the maximum phase length is 2^CNT_W − 1 cycles.
- Reset, including mid-burst: all outputs go to 0 and all FSMs go to IDLE asynchronously. Shadow registers clear to 0.

## Timing
- Reset values: `signal=0`, `busy=0`, `done=0` for every channel.
- All outputs are registered; there are no combinational input-to-output paths.
- Start latency: `start` sampled at edge k gives `signal=1` and `busy=1` from edge k.
- The first pulse occupies cycles k..k+H−1. Pulse period is H+L.
- One-shot with N pulses: `busy` is high for N·H + (N−1)·L cycles. `done` is high in the cycle after the final high cycle, and `busy=0` in that same cycle.
- A new `start` is accepted in the same cycle `done` is high (the channel is IDLE then).

## Structure
- Shared package `pulse_pkg` holds:
  - the state encoding enum (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - the mode constants MODE_ONESHOT=1'b0 and MODE_CONT=1'b1.
- One sub-module, `pulse_channel`, parametrised by CNT_W. It contains the FSM, shadow registers, phase counter and pulse counter.
- The top level instantiates `CHANNELS` copies in a generate loop and handles slicing of the packed vectors.

## Test plan
- Reset check: assert `reset` mid-cycle during an active burst → all outputs are 0 immediately. After release, a start on ch0 behaves normally.
- One-shot, ch0, high_len=3, low_len=3, count=2, start at edge 0:
  - `signal` is 1 for cycles 0–2, 0 for cycles 3–5, and 1 for cycles 6–8;
  - `done=1` and `busy=0` in cycle 9.
- Continuous, ch1, high_len=12, low_len=12, mode=1 → square wave with period 24. Then `stop` at cycle 30 → `signal=0` and `busy=0` from cycle 31, with no `done`.
- Edge values, one-shot: high_len=0 and low_len=0 with count=3 → three 1-cycle pulses separated by 1-cycle lows. count=0 → `done` one cycle after start and `signal` never asserted.
- Contention:
  - `start` and `stop` together → the channel stays IDLE.
  - `start` during a burst → waveform unchanged.
  - changing `high_len` mid-burst → widths unchanged.
  - both channels started on the same edge with different settings → each channel matches its own independent expected waveform.
